// File: rtl/scan_chain_pkg.sv
// Shared definitions for the scan chain: default width, scan-mode encoding
// and the shift-counter width helper.
package scan_chain_pkg;

    localparam int SCAN_DEFAULT_WIDTH = 4;

    typedef enum logic {
        SCAN_CAPTURE = 1'b0,
        SCAN_SHIFT   = 1'b1
    } scan_mode_e;

    // Bits needed to count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/scan_chain_scan_cell.sv
// Single mux-D scan flop: synchronous active-low reset, then shift (si)
// or functional capture (d) selected by scan_en.
module scan_cell
    import scan_chain_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic scan_en,
    input  logic si,
    input  logic d,
    output logic q
);

    scan_mode_e mode;
    assign mode = scan_mode_e'(scan_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (mode == SCAN_SHIFT) begin
            q <= si;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/scan_chain.sv
// Parameterised mux-D scan chain of WIDTH cells, scan_in -> q[0] -> ... -> q[WIDTH-1].
// Optional shift counter / chain_loaded flag enabled by `define SCAN_SHIFT_CNT_EN.
module scan_chain
    import scan_chain_pkg::*;
#(
    parameter int               WIDTH     = SCAN_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
`ifdef SCAN_SHIFT_CNT_EN
    ,
    output logic [cnt_width(WIDTH)-1:0] shift_cnt,
    output logic                        chain_loaded
`endif
);

    // Serial input of each cell: cell 0 takes scan_in, cell i takes q[i-1].
    logic [WIDTH-1:0] si_vec;
    assign si_vec = {q[WIDTH-2:0], scan_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        scan_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RESET_VAL[i]),
            .scan_en (scan_en),
            .si      (si_vec[i]),
            .d       (d[i]),
            .q       (q[i])
        );
    end

    assign scan_out = q[WIDTH-1];

`ifdef SCAN_SHIFT_CNT_EN
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    scan_mode_e cnt_mode;
    assign cnt_mode = scan_mode_e'(scan_en);

    // Counts shift edges since the last capture/reset, saturating at WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_cnt <= '0;
        end else if (cnt_mode == SCAN_CAPTURE) begin
            shift_cnt <= '0;
        end else if (shift_cnt != CNT_MAX) begin
            shift_cnt <= shift_cnt + CNT_W'(1);
        end
    end

    assign chain_loaded = (shift_cnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_scan_chain.sv
// Directed self-checking bench for scan_chain (WIDTH=4, RESET_VAL=0);
// counter checks are included when SCAN_SHIFT_CNT_EN is defined.
module tb_scan_chain;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             scan_en;
    logic             scan_in;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             scan_out;
`ifdef SCAN_SHIFT_CNT_EN
    logic [2:0]       shift_cnt;
    logic             chain_loaded;
`endif

    int total = 0;
    int bad   = 0;

    scan_chain #(.WIDTH(WIDTH), .RESET_VAL(4'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .d        (d),
        .q        (q),
        .scan_out (scan_out)
`ifdef SCAN_SHIFT_CNT_EN
        ,
        .shift_cnt    (shift_cnt),
        .chain_loaded (chain_loaded)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held 2 edges with shift/data inputs active
        rst_n = 1'b0; scan_en = 1'b1; scan_in = 1'b1; d = 4'hF;
        tick(); tick();
        chk("reset_q", q, 4'h0);
        chk("reset_so", scan_out, 1'b0);

        rst_n = 1'b1; scan_en = 1'b0; d = 4'h0;
        tick();
        chk("post_reset_q", q, 4'h0);

        // Shift 1,0,1,1
        scan_en = 1'b1;
        scan_in = 1'b1; tick(); chk("sh1_q", q, 4'b0001); chk("sh1_so", scan_out, 1'b0);
        scan_in = 1'b0; tick(); chk("sh2_q", q, 4'b0010); chk("sh2_so", scan_out, 1'b0);
        scan_in = 1'b1; tick(); chk("sh3_q", q, 4'b0101); chk("sh3_so", scan_out, 1'b0);
        scan_in = 1'b1; tick(); chk("sh4_q", q, 4'b1011); chk("sh4_so", scan_out, 1'b1);

        // Capture, then mid-cycle change of d
        scan_en = 1'b0; d = 4'hA;
        tick(); chk("cap_q", q, 4'hA);
        d = 4'h5; #2;
        chk("cap_hold_q", q, 4'hA);
        tick(); chk("cap_next_q", q, 4'h5);
        d = 4'hA;
        tick(); chk("cap_again_q", q, 4'hA);

        // Shift out 4'hA with scan_in=0, sampling scan_out before each edge
        scan_en = 1'b1; scan_in = 1'b0;
        chk("so_bit0", scan_out, 1'b1); tick();
        chk("so_bit1", scan_out, 1'b0); tick();
        chk("so_bit2", scan_out, 1'b1); tick();
        chk("so_bit3", scan_out, 1'b0); tick();
        chk("so_empty_q", q, 4'h0);

        // Reset mid-shift
        scan_in = 1'b1; tick(); tick();
        chk("pre_rst_q", q, 4'h3);
        rst_n = 1'b0; tick();
        chk("mid_rst_q", q, 4'h0);
        rst_n = 1'b1; tick();
        chk("resume_q", q, 4'h1);

        // Reset pulse between edges has no effect
        rst_n = 1'b0; #2; rst_n = 1'b1;
        scan_in = 1'b0; tick();
        chk("glitch_rst_q", q, 4'h2);

        // X on d is stored unchanged
        scan_en = 1'b0; d = 4'bx01x;
        tick();
        chk("x_cap_q", q, 4'bx01x);

`ifdef SCAN_SHIFT_CNT_EN
        d = 4'h0; tick();
        chk("cnt_clear", shift_cnt, 3'd0);
        scan_en = 1'b1; scan_in = 1'b1;
        tick(); chk("cnt1", shift_cnt, 3'd1); chk("ld1", chain_loaded, 1'b0);
        tick(); chk("cnt2", shift_cnt, 3'd2); chk("ld2", chain_loaded, 1'b0);
        tick(); chk("cnt3", shift_cnt, 3'd3); chk("ld3", chain_loaded, 1'b0);
        tick(); chk("cnt4", shift_cnt, 3'd4); chk("ld4", chain_loaded, 1'b1);
        tick(); chk("cnt5", shift_cnt, 3'd4); chk("ld5", chain_loaded, 1'b1);
        chk("cnt_chain_q", q, 4'hF);
        scan_en = 1'b0; d = 4'h6;
        tick(); chk("cnt_cap", shift_cnt, 3'd0); chk("ld_cap", chain_loaded, 1'b0);
        chk("cnt_cap_q", q, 4'h6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
